// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one fifo write port among NREQ
// producers. Each grant accepts up to BURST words; writes stall on fifo_full.
// Optional feature macro: FIFO_ARB_STALL_CNT_EN (adds stall_cnt output).
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   req            per-requester write request (word valid while high)
//   req_data       requester i word on bits [i*DWIDTH +: DWIDTH]
//   fifo_full      fifo f_full flag
//   grant          registered one-hot grant, zero when idle
//   owner          registered index of granted requester, zero when idle
//   fifo_wr_en     fifo wr_en (combinational)
//   fifo_data      fifo data_in, zero when no write (combinational)
//   accept         one-hot, word from requester i taken this cycle (combinational)
//   stall_cnt      (macro only) saturating count of stalled burst cycles
module fifo_wr_arbiter #(
  parameter int unsigned DWIDTH = 4,
  parameter int unsigned NREQ   = 4,
  parameter int unsigned IDW    = 2,
  parameter int unsigned BURST  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  input  logic                   fifo_full,
  output logic [NREQ-1:0]        grant,
  output logic [IDW-1:0]         owner,
  output logic                   fifo_wr_en,
  output logic [DWIDTH-1:0]      fifo_data,
  output logic [NREQ-1:0]        accept
`ifdef FIFO_ARB_STALL_CNT_EN
  ,
  output logic [7:0]             stall_cnt
`endif
);

  localparam int unsigned BCW = 4;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] grant_n;
  logic [IDW-1:0]  owner_n;
  logic [IDW-1:0]  rr_ptr, rr_ptr_n;
  logic [BCW-1:0]  beat_cnt, beat_cnt_n;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  idx;
  logic            found;
  logic [IDW-1:0]  owner_inc;
  logic            acc;
  logic            release_grant;
`ifdef FIFO_ARB_STALL_CNT_EN
  logic [7:0]      stall_cnt_n;
`endif

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
`ifdef FIFO_ARB_STALL_CNT_EN
      stall_cnt <= '0;
`endif
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      owner    <= owner_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
`ifdef FIFO_ARB_STALL_CNT_EN
      stall_cnt <= stall_cnt_n;
`endif
    end
  end

  // Arbitration, burst control and write-port outputs
  always_comb begin
    state_n       = state;
    grant_n       = grant;
    owner_n       = owner;
    rr_ptr_n      = rr_ptr;
    beat_cnt_n    = beat_cnt;
    pick          = '0;
    idx           = '0;
    found         = 1'b0;
    acc           = 1'b0;
    release_grant = 1'b0;
    fifo_wr_en    = 1'b0;
    fifo_data     = '0;
    accept        = '0;
`ifdef FIFO_ARB_STALL_CNT_EN
    stall_cnt_n   = stall_cnt;
`endif

    // Rotating search starting at rr_ptr; the last owner sits at the end.
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IDW'((32'(rr_ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    owner_inc = (32'(owner) == NREQ - 1) ? '0 : owner + IDW'(1);

    case (state)
      S_IDLE: begin
        if (found) begin
          state_n = S_BURST;
          owner_n = pick;
          grant_n = NREQ'(1) << pick;
        end
      end
      S_BURST: begin
        acc = grant[owner] & req[owner] & ~fifo_full;
        // Dropped request or final accepted beat ends the burst.
        release_grant = ~req[owner] | (acc & (beat_cnt == BCW'(BURST - 1)));
        if (release_grant) begin
          state_n    = S_IDLE;
          grant_n    = '0;
          owner_n    = '0;
          rr_ptr_n   = owner_inc;
          beat_cnt_n = '0;
        end else if (acc) begin
          beat_cnt_n = beat_cnt + BCW'(1);
        end
`ifdef FIFO_ARB_STALL_CNT_EN
        if (req[owner] && fifo_full && stall_cnt != 8'hFF)
          stall_cnt_n = stall_cnt + 8'd1;
`endif
      end
      default: state_n = S_IDLE;
    endcase

    fifo_wr_en = acc;
    if (acc) begin
      fifo_data = req_data[32'(owner)*DWIDTH +: DWIDTH];
      accept    = NREQ'(1) << owner;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_fifo_wr_arbiter;

  localparam int DW = 4;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int BU = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic [NR-1:0]  req;
  logic [NR*DW-1:0] req_data;
  logic           fifo_full;
  logic [NR-1:0]  grant;
  logic [IW-1:0]  owner;
  logic           fifo_wr_en;
  logic [DW-1:0]  fifo_data;
  logic [NR-1:0]  accept;
`ifdef FIFO_ARB_STALL_CNT_EN
  logic [7:0]     stall_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  fifo_wr_arbiter #(.DWIDTH(DW), .NREQ(NR), .IDW(IW), .BURST(BU)) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .fifo_full(fifo_full),
    .grant(grant),
    .owner(owner),
    .fifo_wr_en(fifo_wr_en),
    .fifo_data(fifo_data),
    .accept(accept)
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: who holds the port, how many words it has written,
  // and where the next search starts.
  bit m_busy;
  int m_own;
  int m_words;
  int m_ptr;

  always @(posedge clock or posedge reset) begin
    int sel;
    if (reset) begin
      m_busy  <= 1'b0;
      m_own   <= 0;
      m_words <= 0;
      m_ptr   <= 0;
    end else if (!m_busy) begin
      sel = -1;
      for (int k = 0; k < NR; k++)
        if (sel < 0 && req[(m_ptr + k) % NR]) sel = (m_ptr + k) % NR;
      if (sel >= 0) begin
        m_busy  <= 1'b1;
        m_own   <= sel;
        m_words <= 0;
      end
    end else begin
      if (!req[m_own] || (!fifo_full && m_words + 1 == BU)) begin
        m_busy  <= 1'b0;
        m_own   <= 0;
        m_words <= 0;
        m_ptr   <= (m_own + 1) % NR;
      end else if (!fifo_full) begin
        m_words <= m_words + 1;
      end
    end
  end

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; req_data = 16'h4321; fifo_full = 1'b0;
    #2;
    tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant got %b want 0000", grant); end
    tests_run++; if (fifo_wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en got %b want 0", fifo_wr_en); end
    tests_run++; if (owner !== 2'd0 || accept !== 4'b0000 || fifo_data !== 4'h0) begin
      tests_failed++; $display("FAIL reset_outs owner=%0d accept=%b data=%h want 0/0000/0", owner, accept, fifo_data); end
    @(posedge clock); @(posedge clock);
    #1 reset = 1'b0;
    #3;
    tests_run++; if (grant !== 4'b0000 || fifo_wr_en !== 1'b0) begin
      tests_failed++; $display("FAIL arb_latency grant=%b wr_en=%b want 0000/0", grant, fifo_wr_en); end
    @(posedge clock); #1;
    tests_run++; if (grant !== 4'b0001) begin tests_failed++; $display("FAIL first_grant got %b want 0001", grant); end
    // Asynchronous reset in the middle of a burst clears everything at once.
    #2 reset = 1'b1;
    #1;
    tests_run++; if (grant !== 4'b0000 || fifo_wr_en !== 1'b0) begin
      tests_failed++; $display("FAIL midburst_reset grant=%b wr_en=%b want 0000/0", grant, fifo_wr_en); end
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_single();
    logic [0:9] pat = 10'b0111101100;
    int left = 6;
    int wi = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req = (left > 0) ? 4'b0100 : 4'b0000;
      req_data = '0;
      req_data[11:8] = 4'(wi);
      #4;
      tests_run++;
      if (fifo_wr_en !== pat[c]) begin tests_failed++; $display("FAIL single_wr c=%0d got %b want %b", c, fifo_wr_en, pat[c]); end
      if (pat[c]) begin
        tests_run++;
        if (fifo_data !== 4'(wi) || accept !== 4'b0100) begin
          tests_failed++; $display("FAIL single_data c=%0d data=%h accept=%b want %h/0100", c, fifo_data, accept, 4'(wi)); end
        left--; wi++;
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_all();
    int b, k;
    do_reset();
    req = 4'b1111;
    req_data = {4'hD, 4'hC, 4'hB, 4'hA};
    for (int c = 0; c < 25; c++) begin
      k = c % 5; b = c / 5;
      #4;
      tests_run++;
      if (k == 0) begin
        if (grant !== 4'b0000 || fifo_wr_en !== 1'b0) begin
          tests_failed++; $display("FAIL all_idle c=%0d grant=%b wr_en=%b want 0000/0", c, grant, fifo_wr_en); end
      end else begin
        if (grant !== 4'(1 << (b % 4)) || owner !== 2'(b % 4) || fifo_wr_en !== 1'b1 || fifo_data !== 4'(10 + b % 4)) begin
          tests_failed++;
          $display("FAIL all_burst c=%0d grant=%b owner=%0d wr_en=%b data=%h want owner %0d data %h",
                   c, grant, owner, fifo_wr_en, fifo_data, b % 4, 4'(10 + b % 4));
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_full();
    logic [0:8] fpat = 9'b000111000;
    logic [0:8] wpat = 9'b011000110;
    logic [0:8] gpat = 9'b011111110;
    int writes = 0;
    do_reset();
    req = 4'b0001;
    req_data = 16'h000A;
    for (int c = 0; c < 9; c++) begin
      fifo_full = fpat[c];
      #4;
      tests_run++;
      if (fifo_wr_en !== wpat[c] || grant !== (gpat[c] ? 4'b0001 : 4'b0000)) begin
        tests_failed++; $display("FAIL full_cycle c=%0d wr_en=%b grant=%b want %b/%b", c, fifo_wr_en, grant, wpat[c], gpat[c]); end
      if (fifo_wr_en === 1'b1) writes++;
      @(posedge clock); #1;
    end
    fifo_full = 1'b0;
    tests_run++;
    if (writes != 4) begin tests_failed++; $display("FAIL full_total got %0d want 4", writes); end
  endtask

  task automatic test_drop();
    int left = 2;
    do_reset();
    req_data = {4'h9, 4'h0, 4'h5, 4'h0};
    for (int c = 0; c < 6; c++) begin
      req = {1'b1, 1'b0, (left > 0), (c >= 3)};
      #4;
      if (c == 1 || c == 2) begin
        tests_run++;
        if (grant !== 4'b0010 || fifo_wr_en !== 1'b1 || fifo_data !== 4'h5) begin
          tests_failed++; $display("FAIL drop_burst c=%0d grant=%b wr_en=%b data=%h want 0010/1/5", c, grant, fifo_wr_en, fifo_data); end
        left--;
      end
      if (c == 3) begin
        tests_run++;
        if (fifo_wr_en !== 1'b0) begin tests_failed++; $display("FAIL drop_nowrite got %b want 0", fifo_wr_en); end
      end
      if (c == 4) begin
        tests_run++;
        if (grant !== 4'b0000) begin tests_failed++; $display("FAIL drop_idle got %b want 0000", grant); end
      end
      if (c == 5) begin
        tests_run++;
        if (grant !== 4'b1000 || owner !== 2'd3 || fifo_data !== 4'h9) begin
          tests_failed++; $display("FAIL drop_regrant grant=%b owner=%0d data=%h want 1000/3/9", grant, owner, fifo_data); end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_random();
    bit pend[NR];
    logic [DW-1:0] wd[NR];
    logic [NR-1:0] e_grant, e_acc;
    logic [IW-1:0] e_owner;
    logic e_wr;
    logic [DW-1:0] e_data;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'($urandom_range(0, 1));
      wd[i] = 4'($urandom);
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        req[i] = pend[i];
        req_data[i*DW +: DW] = wd[i];
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      #4;
      e_grant = m_busy ? 4'(1 << m_own) : 4'b0000;
      e_owner = m_busy ? 2'(m_own) : 2'd0;
      e_wr    = m_busy && req[m_own] && !fifo_full;
      e_data  = e_wr ? wd[m_own] : 4'h0;
      e_acc   = e_wr ? 4'(1 << m_own) : 4'b0000;
      tests_run++;
      if (grant !== e_grant || owner !== e_owner) begin
        tests_failed++; $display("FAIL rand_grant cyc=%0d grant=%b owner=%0d want %b/%0d", cyc, grant, owner, e_grant, e_owner); end
      tests_run++;
      if (fifo_wr_en !== e_wr || fifo_data !== e_data || accept !== e_acc) begin
        tests_failed++; $display("FAIL rand_write cyc=%0d wr_en=%b data=%h accept=%b want %b/%h/%b",
                                 cyc, fifo_wr_en, fifo_data, accept, e_wr, e_data, e_acc); end
      @(posedge clock); #1;
      for (int i = 0; i < NR; i++) begin
        if (e_acc[i]) begin
          pend[i] = 1'($urandom_range(0, 1));
          wd[i] = 4'($urandom);
        end else if (!pend[i]) begin
          pend[i] = ($urandom_range(0, 3) == 0);
          wd[i] = 4'($urandom);
        end
      end
    end
  endtask

`ifdef FIFO_ARB_STALL_CNT_EN
  task automatic test_stall_cnt();
    int wrote = 0;
    do_reset();
    req = 4'b0001;
    req_data = 16'h0003;
    fifo_full = 1'b1;
    for (int c = 0; c < 300; c++) begin
      #4;
      if (fifo_wr_en !== 1'b0) wrote++;
      @(posedge clock); #1;
    end
    tests_run++;
    if (wrote != 0) begin tests_failed++; $display("FAIL stall_nowrite got %0d writes want 0", wrote); end
    tests_run++;
    if (stall_cnt !== 8'd255) begin tests_failed++; $display("FAIL stall_sat got %0d want 255", stall_cnt); end
    fifo_full = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all();
    test_full();
    test_drop();
    test_random();
`ifdef FIFO_ARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
